// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence monitor.
// Holds the monitor state enum, the legal code values and the code width.
package seq_pkg;

   localparam int CODE_W = 3;

   typedef logic [CODE_W-1:0] code_t;

   localparam code_t C0 = 3'd0;
   localparam code_t C2 = 3'd2;
   localparam code_t C3 = 3'd3;
   localparam code_t C4 = 3'd4;
   localparam code_t C5 = 3'd5;

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      LOCKED = 2'd1,
      ERROR  = 2'd2
   } state_t;

   function automatic logic is_legal(input code_t c);
      return (c == C0) || (c == C2) || (c == C3) ||
             (c == C4) || (c == C5);
   endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
// Holds at all-ones instead of wrapping.
module seq_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_succ_chk.sv
// Combinational check of a code pair against the upstream FSM graph.
// code_legal qualifies next alone; succ_legal qualifies the prev->next edge.
module seq_succ_chk
   import seq_pkg::*;
(
   input  logic [CODE_W-1:0] prev,
   input  logic [CODE_W-1:0] next,
   output logic              code_legal,
   output logic              succ_legal
);

   always_comb begin
      code_legal = is_legal(next);
      succ_legal = 1'b0;
      unique case (prev)
         C0:      succ_legal = (next == C3);
         C2:      succ_legal = (next == C4);
         C3:      succ_legal = (next == C2) || (next == C5);
         C4:      succ_legal = (next == C0) || (next == C3);
         C5:      succ_legal = (next == C2);
         default: succ_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq_monitor.sv
// Protocol monitor for the upstream sequence FSM code stream.
// Macro SEQ_MONITOR_CYCLE_CNT_EN adds the completed-loop counter cycle_cnt.
module seq_monitor
   import seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   input  logic              clear,
   output logic              locked,
   output logic              err,
   output logic              err_sticky,
   output logic [CODE_W-1:0] last_code,
   output logic [CNT_W-1:0]  trans_cnt
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
   ,
   output logic [CNT_W-1:0]  cycle_cnt
`endif
);

   state_t      state_q;
   state_t      state_d;
   code_t       last_d;
   logic        err_d;
   logic        sticky_d;
   logic        inc_trans;
   logic        inc_cycle;
   logic        code_legal;
   logic        succ_legal;

   seq_succ_chk u_succ (
      .prev       (last_code),
      .next       (code),
      .code_legal (code_legal),
      .succ_legal (succ_legal)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_code;
      err_d     = 1'b0;
      sticky_d  = err_sticky;
      inc_trans = 1'b0;
      inc_cycle = 1'b0;
      if (clear) begin
         state_d  = UNSYNC;
         last_d   = C0;
         sticky_d = 1'b0;
      end else if (code_valid) begin
         unique case (state_q)
            LOCKED: begin
               if (code_legal && succ_legal) begin
                  last_d    = code;
                  inc_trans = 1'b1;
                  inc_cycle = (last_code == C4) && (code == C0);
               end else begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  state_d  = ERROR;
               end
            end
            // UNSYNC and ERROR resynchronise on any legal code
            default: begin
               if (code_legal) begin
                  last_d  = code;
                  state_d = LOCKED;
               end else begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  state_d  = ERROR;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= UNSYNC;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         last_code  <= C0;
      end else begin
         state_q    <= state_d;
         locked     <= (state_d == LOCKED);
         err        <= err_d;
         err_sticky <= sticky_d;
         last_code  <= last_d;
      end
   end

   seq_sat_cnt #(.W(CNT_W)) u_trans_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (inc_trans),
      .count (trans_cnt)
   );

`ifdef SEQ_MONITOR_CYCLE_CNT_EN
   seq_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (inc_cycle),
      .count (cycle_cnt)
   );
`else
   logic unused_cycle;
   assign unused_cycle = inc_cycle;
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Bench for seq_monitor: a graph-level model checked every cycle,
// plus directed literal expectations; a CNT_W=2 copy covers saturation.
module tb_seq_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       code_valid = 1'b0;
   logic       clear = 1'b0;
   logic [2:0] code = 3'd0;

   logic       locked, err, err_sticky;
   logic [2:0] last_code;
   logic [7:0] trans_cnt;
   logic       locked_n, err_n, err_sticky_n;
   logic [2:0] last_code_n;
   logic [1:0] trans_cnt_n;
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
   logic [7:0] cycle_cnt;
   logic [1:0] cycle_cnt_n;
`endif

   int total = 0;
   int bad   = 0;

   bit m_lock, m_err, m_sticky;
   int m_last, m_trans, m_cyc;

   seq_monitor #(.CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .code_valid (code_valid),
      .code       (code),
      .clear      (clear),
      .locked     (locked),
      .err        (err),
      .err_sticky (err_sticky),
      .last_code  (last_code),
      .trans_cnt  (trans_cnt)
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt)
`endif
   );

   seq_monitor #(.CNT_W(2)) dut_n (
      .clk        (clk),
      .reset      (reset),
      .code_valid (code_valid),
      .code       (code),
      .clear      (clear),
      .locked     (locked_n),
      .err        (err_n),
      .err_sticky (err_sticky_n),
      .last_code  (last_code_n),
      .trans_cnt  (trans_cnt_n)
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt_n)
`endif
   );

   initial forever #5 clk = ~clk;

   function automatic bit legal(input int c);
      return c inside {0, 2, 3, 4, 5};
   endfunction

   // Allowed edges encoded as prev*8+next
   function automatic bit succ(input int p, input int n);
      int edges[7] = '{3, 20, 26, 29, 32, 35, 42};
      foreach (edges[i])
         if (edges[i] == p * 8 + n) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update and per-cycle compare
   always begin
      @(posedge clk);
      m_err = 1'b0;
      if (!reset || clear) begin
         m_lock = 0; m_sticky = 0; m_last = 0; m_trans = 0; m_cyc = 0;
      end else if (code_valid) begin
         if (m_lock && succ(m_last, int'(code))) begin
            if (m_last == 4 && code == 3'd0) m_cyc++;
            m_trans++;
            m_last = int'(code);
         end else if (!m_lock && legal(int'(code))) begin
            m_lock = 1;
            m_last = int'(code);
         end else begin
            m_lock = 0; m_err = 1; m_sticky = 1;
         end
      end
      #1;
      chk("locked", locked, m_lock);
      chk("err", err, m_err);
      chk("err_sticky", err_sticky, m_sticky);
      chk("last_code", last_code, m_last);
      chk("trans_cnt", trans_cnt, sat(m_trans, 8));
      chk("locked_n", locked_n, m_lock);
      chk("err_n", err_n, m_err);
      chk("last_code_n", last_code_n, m_last);
      chk("trans_cnt_n", trans_cnt_n, sat(m_trans, 2));
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
      chk("cycle_cnt", cycle_cnt, sat(m_cyc, 8));
      chk("cycle_cnt_n", cycle_cnt_n, sat(m_cyc, 2));
`endif
   end

   task automatic step(input bit v, input int c, input bit clr = 1'b0);
      @(negedge clk);
      code_valid = v;
      code = 3'(c);
      clear = clr;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_trans", trans_cnt, 0);
      @(negedge clk);
      reset = 1'b1;

      step(1, 0);
      chk("lock_first", locked, 1);
      step(1, 3); step(1, 2); step(1, 4); step(1, 0);
      chk("loop_trans", trans_cnt, 4);
      chk("loop_err", err_sticky, 0);
`ifdef SEQ_MONITOR_CYCLE_CNT_EN
      chk("loop_cycle", cycle_cnt, 1);
`endif
      step(1, 3);
      chk("sat_trans_n", trans_cnt_n, 3);
      chk("trans_5", trans_cnt, 5);

      step(1, 4);
      chk("bad_err", err, 1);
      chk("bad_sticky", err_sticky, 1);
      chk("bad_locked", locked, 0);
      chk("bad_last", last_code, 3);
      step(0, 0);
      chk("err_pulse", err, 0);
      chk("sticky_hold", err_sticky, 1);

      step(1, 0, 1'b1);
      chk("clr_trans", trans_cnt, 0);
      chk("clr_sticky", err_sticky, 0);
      chk("clr_locked", locked, 0);
      chk("clr_last", last_code, 0);

      step(1, 6);
      chk("ill_err", err, 1);
      chk("ill_locked", locked, 0);
      step(1, 5);
      chk("rel_locked", locked, 1);
      chk("rel_last", last_code, 5);
      chk("rel_trans", trans_cnt, 0);

      step(1, 0, 1'b1);
      step(1, 0);
      repeat (3) step(0, 0);
      step(1, 3);
      chk("idle_trans", trans_cnt, 1);
      chk("idle_err", err_sticky, 0);

      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_locked", locked, 0);
      chk("async_trans", trans_cnt, 0);
      chk("async_last", last_code, 0);
      @(negedge clk);
      reset = 1'b1;

      step(1, 2);
      chk("post_rst_locked", locked, 1);
      chk("post_rst_last", last_code, 2);
      step(1, 2);
      chk("repeat_err", err, 1);
      step(1, 1);
      chk("err_again", err, 1);
      step(1, 4);
      step(1, 0);
      chk("end_trans", trans_cnt, 1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
